// File: rtl/unit_clause_evaluator_if.sv
// Clause-in / result-out bundle between the BCP clause fetch and the unit-clause evaluator.
// The master drives a clause each cycle and receives the registered evaluation one cycle later.
interface unit_clause_evaluator_if #(
    parameter int VAR_PER_CLAUSE = 5,
    parameter int NUM_VARIABLE   = 128
);
    localparam int VW = (NUM_VARIABLE > 1) ? $clog2(NUM_VARIABLE) : 1;
    localparam int CW = $clog2(VAR_PER_CLAUSE + 1);

    logic                               in_valid;
    logic [VAR_PER_CLAUSE-1:0]          unassign;
    logic [VAR_PER_CLAUSE-1:0]          clause_mask;
    logic [VAR_PER_CLAUSE-1:0]          clause_pole;
    logic [VAR_PER_CLAUSE-1:0][VW-1:0]  variable;

    logic                               out_valid;
    logic                               is_unit_clause;
    logic [VW-1:0]                      implied_variable;
    logic                               new_val;
    logic                               is_conflict;
    logic [CW-1:0]                      unassigned_count;

    modport master (
        output in_valid, unassign, clause_mask, clause_pole, variable,
        input  out_valid, is_unit_clause, implied_variable, new_val, is_conflict, unassigned_count
    );

    modport slave (
        input  in_valid, unassign, clause_mask, clause_pole, variable,
        output out_valid, is_unit_clause, implied_variable, new_val, is_conflict, unassigned_count
    );
endinterface

// File: rtl/unit_clause_evaluator.sv
// Per-clause unit-propagation check: decides unit/conflict for one clause and yields the
// implied variable and its value, registered with a single cycle of latency.
module unit_clause_evaluator #(
    parameter int VAR_PER_CLAUSE = 5,
    parameter int NUM_VARIABLE   = 128
) (
    input  logic                 clock,
    input  logic                 reset_n,
    unit_clause_evaluator_if.slave bus
);
    localparam int VW = (NUM_VARIABLE > 1) ? $clog2(NUM_VARIABLE) : 1;
    localparam int CW = $clog2(VAR_PER_CLAUSE + 1);

    logic [VAR_PER_CLAUSE-1:0]         active;
    logic [VAR_PER_CLAUSE-1:0][VW-1:0] sel_terms;
    logic [VAR_PER_CLAUSE-1:0]         pole_terms;
    logic [VW-1:0]                     sel_or;
    logic [CW-1:0]                     count_d;
    logic                              unit_d;
    logic [VW-1:0]                     implied_d;
    logic                              new_val_d;
    logic                              conflict_d;

    logic                              out_valid_q;
    logic                              unit_q;
    logic [VW-1:0]                     implied_q;
    logic                              new_val_q;
    logic                              conflict_q;
    logic [CW-1:0]                     count_q;

    assign active = bus.unassign & bus.clause_mask;

    // Each slot contributes only when active; OR-ing the terms selects the single
    // active slot without any priority ordering between slots.
    genvar gi;
    generate
        for (gi = 0; gi < VAR_PER_CLAUSE; gi++) begin : g_slot
            assign sel_terms[gi]  = active[gi] ? bus.variable[gi] : '0;
            assign pole_terms[gi] = active[gi] & ~bus.clause_pole[gi];
        end
    endgenerate

    always_comb begin
        count_d = '0;
        sel_or  = '0;
        for (int i = 0; i < VAR_PER_CLAUSE; i++) begin
            count_d = count_d + CW'(active[i]);
            sel_or  = sel_or | sel_terms[i];
        end
    end

    assign unit_d     = (count_d == CW'(1));
    assign implied_d  = unit_d ? sel_or : '0;
    assign new_val_d  = unit_d & (|pole_terms);
    assign conflict_d = (|bus.clause_mask) && (active == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            unit_q      <= 1'b0;
            implied_q   <= '0;
            new_val_q   <= 1'b0;
            conflict_q  <= 1'b0;
            count_q     <= '0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                unit_q     <= unit_d;
                implied_q  <= implied_d;
                new_val_q  <= new_val_d;
                conflict_q <= conflict_d;
                count_q    <= count_d;
            end
        end
    end

    assign bus.out_valid        = out_valid_q;
    assign bus.is_unit_clause   = unit_q;
    assign bus.implied_variable = implied_q;
    assign bus.new_val          = new_val_q;
    assign bus.is_conflict      = conflict_q;
    assign bus.unassigned_count = count_q;
endmodule

// File: tb/tb_unit_clause_evaluator.sv
// Directed bench for unit_clause_evaluator: hand-computed results for unit, non-unit,
// conflict, empty, reset and back-to-back clauses.
module tb_unit_clause_evaluator;
    localparam int VPC = 5;
    localparam int NV  = 128;

    logic clock;
    logic reset_n;
    int   tests_run;
    int   tests_failed;

    unit_clause_evaluator_if #(.VAR_PER_CLAUSE(VPC), .NUM_VARIABLE(NV)) bus ();

    unit_clause_evaluator #(.VAR_PER_CLAUSE(VPC), .NUM_VARIABLE(NV)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // {out_valid, is_unit, implied[6:0], new_val, is_conflict, count[2:0]}
    logic [13:0] obs;
    assign obs = {bus.out_valid, bus.is_unit_clause, bus.implied_variable,
                  bus.new_val, bus.is_conflict, bus.unassigned_count};

    always #5 clock = ~clock;

    function automatic logic [13:0] expv(input logic v, input logic u, input logic [6:0] imp,
                                         input logic nv, input logic c, input logic [2:0] cnt);
        return {v, u, imp, nv, c, cnt};
    endfunction

    task automatic drive(input logic [4:0] un, input logic [4:0] mask, input logic [4:0] pole);
        bus.in_valid    = 1'b1;
        bus.unassign    = un;
        bus.clause_mask = mask;
        bus.clause_pole = pole;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        logic [13:0] e;
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            r = $urandom;
            drive(r[4:0], r[9:5], r[14:10]);
            @(posedge clock); #1;
            e = '0;
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("[TB] FAIL reset_hold%0d: got %h expected %h", i, obs, e);
            end else $display("[TB] reset_hold%0d ok %h", i, obs);
        end
        #3 reset_n = 1'b1;
        drive(5'b10000, 5'b11111, 5'b00000);
        @(posedge clock); #1;
        e = expv(1, 1, 7'd100, 1, 0, 3'd1);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("[TB] FAIL first_after_release: got %h expected %h", obs, e);
        end else $display("[TB] first_after_release ok %h", obs);
        #2 reset_n = 1'b0;
        #1;
        e = '0;
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("[TB] FAIL async_clear: got %h expected %h", obs, e);
        end else $display("[TB] async_clear ok %h", obs);
        @(posedge clock); #1;
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("[TB] FAIL inflight_discard: got %h expected %h", obs, e);
        end else $display("[TB] inflight_discard ok %h", obs);
        #3 reset_n = 1'b1;
    endtask

    task automatic test_unit_polarity();
        logic [13:0] e;
        drive(5'b10000, 5'b11111, 5'b00000);
        @(posedge clock); #1;
        e = expv(1, 1, 7'd100, 1, 0, 3'd1);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("[TB] FAIL unit_pos: got %h expected %h", obs, e);
        end else $display("[TB] unit_pos ok %h", obs);
        drive(5'b10000, 5'b11111, 5'b11111);
        @(posedge clock); #1;
        e = expv(1, 1, 7'd100, 0, 0, 3'd1);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("[TB] FAIL unit_neg: got %h expected %h", obs, e);
        end else $display("[TB] unit_neg ok %h", obs);
        drive(5'b00001, 5'b11111, 5'b00001);
        @(posedge clock); #1;
        e = expv(1, 1, 7'd5, 0, 0, 3'd1);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("[TB] FAIL unit_slot0: got %h expected %h", obs, e);
        end else $display("[TB] unit_slot0 ok %h", obs);
    endtask

    task automatic test_masked_slot();
        logic [13:0] e;
        drive(5'b00100, 5'b11110, 5'b00000);
        @(posedge clock); #1;
        e = expv(1, 1, 7'd17, 1, 0, 3'd1);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("[TB] FAIL masked_mid: got %h expected %h", obs, e);
        end else $display("[TB] masked_mid ok %h", obs);
        drive(5'b00011, 5'b11110, 5'b00000);
        @(posedge clock); #1;
        e = expv(1, 1, 7'd9, 1, 0, 3'd1);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("[TB] FAIL masked_slot0: got %h expected %h", obs, e);
        end else $display("[TB] masked_slot0 ok %h", obs);
    endtask

    task automatic test_non_unit();
        logic [13:0] e;
        drive(5'b10001, 5'b11111, 5'b00000);
        @(posedge clock); #1;
        e = expv(1, 0, 7'd0, 0, 0, 3'd2);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("[TB] FAIL two_active: got %h expected %h", obs, e);
        end else $display("[TB] two_active ok %h", obs);
        drive(5'b11111, 5'b11111, 5'b00000);
        @(posedge clock); #1;
        e = expv(1, 0, 7'd0, 0, 0, 3'd5);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("[TB] FAIL all_active: got %h expected %h", obs, e);
        end else $display("[TB] all_active ok %h", obs);
    endtask

    task automatic test_conflict_empty();
        logic [13:0] e;
        drive(5'b00000, 5'b11111, 5'b00000);
        @(posedge clock); #1;
        e = expv(1, 0, 7'd0, 0, 1, 3'd0);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("[TB] FAIL conflict: got %h expected %h", obs, e);
        end else $display("[TB] conflict ok %h", obs);
        drive(5'b11111, 5'b00000, 5'b00000);
        @(posedge clock); #1;
        e = expv(1, 0, 7'd0, 0, 0, 3'd0);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("[TB] FAIL empty_mask: got %h expected %h", obs, e);
        end else $display("[TB] empty_mask ok %h", obs);
    endtask

    task automatic test_back_to_back();
        logic [13:0] exp_tab [3];
        logic [4:0]  un_tab  [3];
        logic [4:0]  pl_tab  [3];
        logic [13:0] e;
        un_tab[0] = 5'b10000; pl_tab[0] = 5'b00000; exp_tab[0] = expv(1, 1, 7'd100, 1, 0, 3'd1);
        un_tab[1] = 5'b00011; pl_tab[1] = 5'b00010; exp_tab[1] = expv(1, 0, 7'd0, 0, 0, 3'd2);
        un_tab[2] = 5'b01000; pl_tab[2] = 5'b01000; exp_tab[2] = expv(1, 1, 7'd33, 0, 0, 3'd1);
        for (int i = 0; i < 3; i++) begin
            drive(un_tab[i], 5'b11111, pl_tab[i]);
            @(posedge clock); #1;
            tests_run++;
            if (obs !== exp_tab[i]) begin
                tests_failed++;
                $display("[TB] FAIL b2b%0d: got %h expected %h", i, obs, exp_tab[i]);
            end else $display("[TB] b2b%0d ok %h", i, obs);
        end
        bus.in_valid = 1'b0;
        bus.unassign = 5'b11111;
        @(posedge clock); #1;
        e = expv(0, 1, 7'd33, 0, 0, 3'd1);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("[TB] FAIL idle_hold: got %h expected %h", obs, e);
        end else $display("[TB] idle_hold ok %h", obs);
    endtask

    initial begin
        clock            = 1'b0;
        reset_n          = 1'b0;
        tests_run        = 0;
        tests_failed     = 0;
        bus.in_valid     = 1'b0;
        bus.unassign     = '0;
        bus.clause_mask  = '0;
        bus.clause_pole  = '0;
        bus.variable[0]  = 7'd5;
        bus.variable[1]  = 7'd9;
        bus.variable[2]  = 7'd17;
        bus.variable[3]  = 7'd33;
        bus.variable[4]  = 7'd100;
        #2;
        test_reset();
        test_unit_polarity();
        test_masked_slot();
        test_non_unit();
        test_conflict_empty();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/unit_clause_evaluator.md
Name: unit_clause_evaluator

Overview:
Per-clause unit-propagation evaluator for the SAT solver datapath (sat_solver). It takes one clause of up to VAR_PER_CLAUSE literals and the assignment state of each literal. It decides whether the clause is unit (exactly one active literal unassigned) and, if so, outputs the implied variable index and the value that satisfies it. Results are registered (one-cycle latency) and feed the implication/BCP queue.

Parameters:
VAR_PER_CLAUSE, 5, literal slots per clause
NUM_VARIABLE, 128, number of solver variables; index width VW = $clog2(NUM_VARIABLE) (7 at default)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  clause inputs valid this cycle
unassign  input  VAR_PER_CLAUSE  bit i = 1: literal slot i currently unassigned
clause_mask  input  VAR_PER_CLAUSE  bit i = 1: slot i holds a real literal; 0 = unused slot
clause_pole  input  VAR_PER_CLAUSE  bit i = polarity of slot i; 0 = positive literal, 1 = negated literal
variable  input  VAR_PER_CLAUSE x VW  packed array; variable[i] = variable index of slot i
out_valid  output  1  registered results valid
is_unit_clause  output  1  exactly one active unassigned literal
implied_variable  output  VW  variable index of the unit literal
new_val  output  1  value to assign to implied_variable
is_conflict  output  1  active clause with no unassigned literal (all assigned literals false)
unassigned_count  output  $clog2(VAR_PER_CLAUSE+1)  popcount of (unassign & clause_mask)

Behaviour:
- Caller contract: only clauses whose assigned literals all evaluate false are presented. The block does not check assigned literal values.
- active = unassign & clause_mask. Unassign bits in masked-off slots are ignored.
- Combinational evaluation, all from active:
  - unit = (popcount(active) == 1).
  - k = index of the single set bit of active.
  - implied = unit ? variable[k] : 0.
  - nv = unit ? ~clause_pole[k] : 0. Positive literal implies 1; negated literal implies 0.
  - conflict = (clause_mask != 0) && (active == 0).
- Registered stage on rising edge of clock:
  - When in_valid = 1: all result outputs load the evaluation and out_valid <= 1.
  - When in_valid = 0: out_valid <= 0 and the data outputs hold their previous values.
- Latency: exactly 1 cycle from in_valid sampled high to out_valid high with its results. Fully pipelined; a new clause is accepted every cycle and there is no backpressure.
- Reset (reset_n = 0, asynchronous, any time): out_valid, is_unit_clause, implied_variable, new_val, is_conflict and unassigned_count all clear to 0 immediately.
  - Reset asserted mid-stream discards the in-flight result.
  - The first evaluation after release occurs on the first rising edge with reset_n = 1 and in_valid = 1.
- Boundary cases:
  - clause_mask = 0: unit = 0, conflict = 0, count = 0.
  - Two or more active literals: unit = 0; implied_variable = 0 and new_val = 0, not don't-care.
  - All slots active: count = VAR_PER_CLAUSE, unit = 0.
  - Unit literal in slot 0 or in slot VAR_PER_CLAUSE-1 must both work; selection must not assume any priority order.
- Duplicate variable indices across slots need no special handling.

Test Plan:
- Reset: hold reset_n = 0 with random inputs and in_valid = 1 -> all outputs 0. Assert reset_n mid-stream -> outputs clear without waiting for a clock edge.
- Unit, positive polarity: unassign = 10000, mask = 11111, pole = 00000, variable = {5,9,17,33,100} -> next cycle out_valid = 1, is_unit = 1, implied = 100, new_val = 1, count = 1, conflict = 0.
- Unit, negative polarity: same inputs with pole = 11111 -> implied = 100, new_val = 0, is_unit = 1.
- Masked slot plus middle unit: unassign = 00100, mask = 11110, pole = 00000 -> is_unit = 1, implied = variable[2] = 17, new_val = 1. Separately, unassign = 00011, mask = 11110 -> is_unit = 1, implied = variable[1] = 9.
- Non-unit: unassign = 10001, mask = 11111 -> is_unit = 0, implied = 0, new_val = 0, count = 2. unassign = 11111 -> count = 5, is_unit = 0.
- Conflict and empty: unassign = 00000, mask = 11111 -> is_conflict = 1, is_unit = 0. mask = 00000 -> all flags 0. Back-to-back in_valid every cycle for 3 clauses -> each result appears exactly one cycle later; in_valid low -> out_valid = 0 with data held.
